// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring divide
// on operand magnitudes, followed by a one-cycle sign fix and a one-cycle done pulse.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [4:0]      aluctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_MUL    = 5'd21;
    localparam logic [4:0] OP_MULH   = 5'd22;
    localparam logic [4:0] OP_MULHSU = 5'd23;
    localparam logic [4:0] OP_DIV    = 5'd25;
    localparam logic [4:0] OP_REM    = 5'd27;
    localparam logic [4:0] OP_REMU   = 5'd28;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              is_div_q, is_div_d;
    logic              is_rem_q, is_rem_d;
    logic              mul_hi_q, mul_hi_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_a_q, neg_a_d;
    logic              special_q, special_d;

    logic              op_valid, op_is_div, op_is_rem, sgn_a, sgn_b;
    logic              a_neg, b_neg, div_zero, div_ovf, q_bit;
    logic [XLEN-1:0]   mag_a, mag_b, preset, quo_fix, rem_fix;
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic [2*XLEN-1:0] prod_neg;

    assign op_valid  = (aluctrl_i >= OP_MUL) && (aluctrl_i <= OP_REMU);
    assign op_is_div = (aluctrl_i >= OP_DIV) && (aluctrl_i <= OP_REMU);
    assign op_is_rem = (aluctrl_i == OP_REM) || (aluctrl_i == OP_REMU);
    assign sgn_a     = (aluctrl_i == OP_MUL) || (aluctrl_i == OP_MULH) || (aluctrl_i == OP_MULHSU)
                    || (aluctrl_i == OP_DIV) || (aluctrl_i == OP_REM);
    assign sgn_b     = (aluctrl_i == OP_MUL) || (aluctrl_i == OP_MULH)
                    || (aluctrl_i == OP_DIV) || (aluctrl_i == OP_REM);
    assign a_neg     = sgn_a & op_a_i[XLEN-1];
    assign b_neg     = sgn_b & op_b_i[XLEN-1];
    assign mag_a     = a_neg ? -op_a_i : op_a_i;
    assign mag_b     = b_neg ? -op_b_i : op_b_i;

    // Signed overflow only exists for DIV/REM, which are exactly the signed divide codes.
    assign div_zero  = op_is_div && (op_b_i == '0);
    assign div_ovf   = op_is_div && sgn_b && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    assign preset    = div_zero ? (op_is_rem ? op_a_i : '1) : (op_is_rem ? '0 : op_a_i);

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_shift = {rem_q, prod_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};
    assign q_bit     = ~rem_diff[XLEN];

    assign prod_neg  = -prod_q;
    assign quo_fix   = neg_res_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix   = neg_a_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        is_div_d  = is_div_q;
        is_rem_d  = is_rem_q;
        mul_hi_d  = mul_hi_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        special_d = special_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i && op_valid) begin
                    is_div_d  = op_is_div;
                    is_rem_d  = op_is_rem;
                    mul_hi_d  = (aluctrl_i != OP_MUL);
                    neg_a_d   = a_neg;
                    neg_res_d = a_neg ^ b_neg;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(XLEN);
                    if (div_zero || div_ovf) begin
                        special_d = 1'b1;
                        prod_d    = {{XLEN{1'b0}}, preset};
                        state_d   = FIX;
                    end else begin
                        special_d = 1'b0;
                        state_d   = CALC;
                        // Low half holds the multiplier or the dividend; opnd holds the addend or divisor.
                        if (op_is_div) begin
                            opnd_d = mag_b;
                            prod_d = {{XLEN{1'b0}}, mag_a};
                        end else begin
                            opnd_d = mag_a;
                            prod_d = {{XLEN{1'b0}}, mag_b};
                        end
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (is_div_q) begin
                        rem_d  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                        prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], q_bit};
                    end else begin
                        prod_d = {mul_sum, prod_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (special_q) begin
                        result_d = prod_q[XLEN-1:0];
                    end else if (is_rem_q) begin
                        result_d = rem_fix;
                    end else if (is_div_q) begin
                        result_d = quo_fix;
                    end else if (mul_hi_q) begin
                        result_d = neg_res_q ? prod_neg[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
                    end else begin
                        result_d = neg_res_q ? prod_neg[XLEN-1:0] : prod_q[XLEN-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            is_div_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            mul_hi_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            is_div_q  <= is_div_d;
            is_rem_q  <= is_rem_d;
            mul_hi_q  <= mul_hi_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            special_q <= special_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M cases plus random operations, each checked
// against a plain-arithmetic model for result, done latency and busy window.
module tb_muldiv_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [4:0]  aluctrl_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model_result;

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .aluctrl_i (aluctrl_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard time limit so a wedged design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] refModel(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (code)
            5'd21: begin p = sa * sb; return p[31:0]; end
            5'd22: begin p = sa * sb; return p[63:32]; end
            5'd23: begin p = sa * ub; return p[63:32]; end
            5'd24: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'd25: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            5'd26: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'd27: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            5'd28: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic isSpecial(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        logic is_div;
        logic is_sdiv;
        is_div  = (code >= 5'd25) && (code <= 5'd28);
        is_sdiv = (code == 5'd25) || (code == 5'd27);
        return (is_div && b == 32'd0) || (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One operation: accept, then watch every cycle of the expected busy window.
    // A flush is applied at cycle flush_at when it falls inside CALC/FIX.
    task automatic applyStimulus(input string tag, input logic [4:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input int flush_at);
        logic        valid;
        logic        do_flush;
        logic        exp_busy;
        logic [31:0] exp_res;
        logic [31:0] res_seen;
        int          exp_lat;
        int          window;
        int          done_cyc;
        int          done_cnt;
        int          busy_bad;
        valid    = (code >= 5'd21) && (code <= 5'd28);
        exp_lat  = isSpecial(code, a, b) ? 2 : 34;
        do_flush = valid && (flush_at > 0) && (flush_at <= exp_lat - 2);
        exp_res  = valid ? refModel(code, a, b) : model_result;
        window   = !valid ? 4 : (do_flush ? flush_at + 4 : exp_lat);

        @(negedge clk_i);
        start_i   = 1'b1;
        aluctrl_i = code;
        op_a_i    = a;
        op_b_i    = b;
        @(posedge clk_i);
        #1;
        start_i   = 1'b0;
        aluctrl_i = 5'($urandom);
        op_a_i    = $urandom;
        op_b_i    = $urandom;

        done_cyc = 0;
        done_cnt = 0;
        busy_bad = 0;
        res_seen = 32'd0;
        for (int c = 1; c <= window; c++) begin
            @(negedge clk_i);
            exp_busy = valid && (do_flush ? (c <= flush_at) : (c <= exp_lat));
            if (busy_o !== exp_busy) busy_bad++;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    res_seen = result_o;
                end
            end
            flush_i = do_flush && (c == flush_at);
            // A start while busy must be ignored.
            if (valid && !do_flush && exp_lat == 34) begin
                start_i = (c == 3);
                if (c == 3) begin
                    aluctrl_i = 5'd25;
                    op_a_i    = $urandom;
                    op_b_i    = 32'd0;
                end
            end
        end
        start_i = 1'b0;
        flush_i = 1'b0;
        if (done_cyc == 0) res_seen = result_o;
        if (valid && !do_flush) model_result = exp_res;

        checkOutput({tag, "/done_count"}, 32'(done_cnt), (valid && !do_flush) ? 32'd1 : 32'd0);
        checkOutput({tag, "/done_cycle"}, 32'(done_cyc), (valid && !do_flush) ? 32'(exp_lat) : 32'd0);
        checkOutput({tag, "/busy_window"}, 32'(busy_bad), 32'd0);
        checkOutput({tag, "/result"}, res_seen, model_result);
    endtask

    initial begin
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst_ni       = 1'b0;
        start_i      = 1'b0;
        flush_i      = 1'b0;
        aluctrl_i    = 5'd0;
        op_a_i       = 32'd0;
        op_b_i       = 32'd0;
        model_result = 32'd0;

        repeat (2) @(negedge clk_i);
        checkOutput("reset/busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset/done", {31'd0, done_o}, 32'd0);
        checkOutput("reset/result", result_o, 32'd0);
        rst_ni = 1'b1;

        applyStimulus("mul_7xm3",    5'd21, 32'd7,          32'hFFFF_FFFD, 0);
        applyStimulus("mulh_min",    5'd22, 32'h8000_0000,  32'h8000_0000, 0);
        applyStimulus("mulhu_max",   5'd24, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        applyStimulus("mulhsu_m1x2", 5'd23, 32'hFFFF_FFFF,  32'd2,         0);
        applyStimulus("div_m7_2",    5'd25, 32'hFFFF_FFF9,  32'd2,         0);
        applyStimulus("rem_m7_2",    5'd27, 32'hFFFF_FFF9,  32'd2,         0);
        applyStimulus("divu_100_7",  5'd26, 32'd100,        32'd7,         0);
        applyStimulus("remu_100_7",  5'd28, 32'd100,        32'd7,         0);
        applyStimulus("divu_by0",    5'd26, 32'd5,          32'd0,         0);
        applyStimulus("rem_by0",     5'd27, 32'd5,          32'd0,         0);
        applyStimulus("div_ovf",     5'd25, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        applyStimulus("rem_ovf",     5'd27, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        applyStimulus("flush_c10",   5'd21, 32'd1234,       32'd5678,      10);
        applyStimulus("after_flush", 5'd22, 32'h1234_5678,  32'h9ABC_DEF0, 0);
        applyStimulus("bad_code5",   5'd5,  32'd3,          32'd4,         0);
        applyStimulus("mul_7xm3_b",  5'd21, 32'd7,          32'hFFFF_FFFD, 0);

        // A start presented together with flush in IDLE must not be accepted.
        @(negedge clk_i);
        start_i   = 1'b1;
        flush_i   = 1'b1;
        aluctrl_i = 5'd21;
        op_a_i    = 32'd9;
        op_b_i    = 32'd9;
        @(negedge clk_i);
        start_i = 1'b0;
        flush_i = 1'b0;
        checkOutput("flush_start/busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        checkOutput("flush_start/result", result_o, model_result);

        // Asynchronous reset in the middle of CALC clears the outputs at once.
        @(negedge clk_i);
        start_i   = 1'b1;
        aluctrl_i = 5'd26;
        op_a_i    = 32'd1000;
        op_b_i    = 32'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midreset/busy", {31'd0, busy_o}, 32'd0);
        checkOutput("midreset/done", {31'd0, done_o}, 32'd0);
        checkOutput("midreset/result", result_o, 32'd0);
        model_result = 32'd0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        applyStimulus("post_reset", 5'd28, 32'd1000, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            code = 5'($urandom_range(21, 28));
            a    = $urandom;
            b    = $urandom;
            sel  = $urandom_range(0, 7);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                b = 32'($urandom_range(1, 15));
            end else if (sel == 3) begin
                a = 32'h8000_0000;
            end
            applyStimulus("random", code, a, b, (i == 20) ? 12 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
